// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported memory between the fetch (I) and data (D) pipeline ports,
// one transaction at a time, with a per-transaction watchdog and a stall-cycle counter.
//
// state | meaning
// IDLE  | no transaction outstanding, MemReq low
// IBUSY | fetch transaction outstanding, waiting for MemAck
// DBUSY | data transaction outstanding, waiting for MemAck
module mem_port_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IReq,
    input  logic [31:0] IAddr,
    output logic [31:0] IRData,
    output logic        IReady,
    input  logic        DReq,
    input  logic        DWe,
    input  logic [31:0] DAddr,
    input  logic [31:0] DWData,
    output logic [31:0] DRData,
    output logic        DReady,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    input  logic [31:0] MemRData,
    input  logic        MemAck,
    output logic        MemError,
    output logic [15:0] StallCnt
);

    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [7:0]  wait_cnt, wait_nxt;
    logic        mem_req_nxt, mem_we_nxt;
    logic [31:0] mem_addr_nxt, mem_wdata_nxt;
    logic        timeout, grant_i, grant_d;
    logic        stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
            MemReq   <= 1'b0;
            MemWe    <= 1'b0;
            MemAddr  <= 32'd0;
            MemWData <= 32'd0;
            MemError <= 1'b0;
            StallCnt <= 16'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            MemReq   <= mem_req_nxt;
            MemWe    <= mem_we_nxt;
            MemAddr  <= mem_addr_nxt;
            MemWData <= mem_wdata_nxt;
            if (timeout)
                MemError <= 1'b1;
            if (stall && StallCnt != 16'hFFFF)
                StallCnt <= StallCnt + 16'd1;
        end
    end

    always_comb begin
        state_nxt     = state;
        wait_nxt      = wait_cnt;
        mem_req_nxt   = MemReq;
        mem_we_nxt    = MemWe;
        mem_addr_nxt  = MemAddr;
        mem_wdata_nxt = MemWData;
        IReady        = 1'b0;
        DReady        = 1'b0;
        IRData        = 32'd0;
        DRData        = 32'd0;
        timeout       = 1'b0;
        grant_i       = 1'b0;
        grant_d       = 1'b0;

        case (state)
            IDLE: begin
                wait_nxt    = 8'd0;
                mem_req_nxt = 1'b0;
                // Data access belongs to the older instruction, so it wins.
                if (DReq)
                    grant_d = 1'b1;
                else if (IReq)
                    grant_i = 1'b1;
            end
            IBUSY: begin
                timeout = !MemAck && (wait_cnt == WAIT_LAST);
                if (MemAck || timeout) begin
                    IReady = 1'b1;
                    IRData = MemAck ? MemRData : 32'd0;
                    if (MemAck && DReq) begin
                        grant_d = 1'b1;
                    end else begin
                        state_nxt   = IDLE;
                        mem_req_nxt = 1'b0;
                        wait_nxt    = 8'd0;
                    end
                end else begin
                    wait_nxt = wait_cnt + 8'd1;
                end
            end
            DBUSY: begin
                timeout = !MemAck && (wait_cnt == WAIT_LAST);
                if (MemAck || timeout) begin
                    DReady = 1'b1;
                    DRData = MemAck ? MemRData : 32'd0;
                    if (MemAck && IReq) begin
                        grant_i = 1'b1;
                    end else begin
                        state_nxt   = IDLE;
                        mem_req_nxt = 1'b0;
                        wait_nxt    = 8'd0;
                    end
                end else begin
                    wait_nxt = wait_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt   = IDLE;
                mem_req_nxt = 1'b0;
                wait_nxt    = 8'd0;
            end
        endcase

        if (grant_d) begin
            state_nxt     = DBUSY;
            mem_req_nxt   = 1'b1;
            mem_we_nxt    = DWe;
            mem_addr_nxt  = DAddr;
            mem_wdata_nxt = DWData;
            wait_nxt      = 8'd0;
        end
        if (grant_i) begin
            state_nxt    = IBUSY;
            mem_req_nxt  = 1'b1;
            mem_we_nxt   = 1'b0;
            mem_addr_nxt = IAddr;
            wait_nxt     = 8'd0;
        end

        // An ack landing while reset is asserted must not reach the pipeline.
        if (reset) begin
            IReady  = 1'b0;
            DReady  = 1'b0;
            IRData  = 32'd0;
            DRData  = 32'd0;
            timeout = 1'b0;
        end
    end

    assign stall = (IReq && !IReady) || (DReq && !DReady);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected Ready responses into a
// queue, a negedge monitor pops and compares whenever IReady or DReady is seen.
module tb_mem_port_arbiter;

    localparam int TIMEOUT = 12;

    logic        clk;
    logic        reset;
    logic        IReq;
    logic [31:0] IAddr;
    logic [31:0] IRData;
    logic        IReady;
    logic        DReq;
    logic        DWe;
    logic [31:0] DAddr;
    logic [31:0] DWData;
    logic [31:0] DRData;
    logic        DReady;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [31:0] MemRData;
    logic        MemAck;
    logic        MemError;
    logic [15:0] StallCnt;

    mem_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .reset    (reset),
        .IReq     (IReq),
        .IAddr    (IAddr),
        .IRData   (IRData),
        .IReady   (IReady),
        .DReq     (DReq),
        .DWe      (DWe),
        .DAddr    (DAddr),
        .DWData   (DWData),
        .DRData   (DRData),
        .DReady   (DReady),
        .MemReq   (MemReq),
        .MemWe    (MemWe),
        .MemAddr  (MemAddr),
        .MemWData (MemWData),
        .MemRData (MemRData),
        .MemAck   (MemAck),
        .MemError (MemError),
        .StallCnt (StallCnt)
    );

    typedef struct {
        logic        is_d;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void push(input logic is_d, input logic [31:0] data);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        exp_q.push_back(e);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        IReq     = 1'b0;
        IAddr    = 32'd0;
        DReq     = 1'b0;
        DWe      = 1'b0;
        DAddr    = 32'd0;
        DWData   = 32'd0;
        MemRData = 32'd0;
        MemAck   = 1'b0;
        repeat (2) step();
        reset = 1'b0;
    endtask

    // Monitor: every Ready pulse must match the oldest expectation; RData idle at zero.
    always @(negedge clk) begin
        exp_t e;
        if (IReady || DReady) begin
            vectors++;
            if (IReady && DReady) begin
                miscompares++;
                $display("FAIL both_ready: IReady=%b DReady=%b, expected one", IReady, DReady);
            end else if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_ready: IReady=%b DReady=%b, expected none", IReady, DReady);
            end else begin
                e = exp_q.pop_front();
                if (DReady !== e.is_d) begin
                    miscompares++;
                    $display("FAIL ready_port: got DReady=%b, expected DReady=%b", DReady, e.is_d);
                end else if ((e.is_d ? DRData : IRData) !== e.data) begin
                    miscompares++;
                    $display("FAIL ready_data: got %h, expected %h", e.is_d ? DRData : IRData, e.data);
                end
            end
        end
        if (!IReady && IRData !== 32'd0) begin
            vectors++;
            miscompares++;
            $display("FAIL irdata_idle: got %h, expected 0", IRData);
        end
        if (!DReady && DRData !== 32'd0) begin
            vectors++;
            miscompares++;
            $display("FAIL drdata_idle: got %h, expected 0", DRData);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        do_reset();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_memreq", {31'd0, MemReq}, 32'd0);
        chk("rst_memwe", {31'd0, MemWe}, 32'd0);
        chk("rst_memaddr", MemAddr, 32'd0);
        chk("rst_memwdata", MemWData, 32'd0);
        chk("rst_memerror", {31'd0, MemError}, 32'd0);
        chk("rst_stallcnt", {16'd0, StallCnt}, 32'd0);
        step();
        reset = 1'b0;

        // Single fetch, ack on the second BUSY cycle
        IReq  = 1'b1;
        IAddr = 32'h100;
        @(negedge clk);
        chk("f1_memreq_idle", {31'd0, MemReq}, 32'd0);
        step();
        @(negedge clk);
        chk("f1_memreq_rise", {31'd0, MemReq}, 32'd1);
        chk("f1_memaddr", MemAddr, 32'h100);
        chk("f1_memwe_b0", {31'd0, MemWe}, 32'd0);
        step();
        push(1'b0, 32'hE3A01005);
        MemAck   = 1'b1;
        MemRData = 32'hE3A01005;
        @(negedge clk);
        chk("f1_memwe_b1", {31'd0, MemWe}, 32'd0);
        step();
        IReq     = 1'b0;
        MemAck   = 1'b0;
        MemRData = 32'd0;
        @(negedge clk);
        chk("f1_memreq_drop", {31'd0, MemReq}, 32'd0);

        // Both request: store goes first, fetch follows without a bubble
        do_reset();
        IReq   = 1'b1;
        IAddr  = 32'h300;
        DReq   = 1'b1;
        DWe    = 1'b1;
        DAddr  = 32'h200;
        DWData = 32'hCAFEF00D;
        step();
        push(1'b1, 32'h11111111);
        MemAck   = 1'b1;
        MemRData = 32'h11111111;
        @(negedge clk);
        chk("pr_memreq_d", {31'd0, MemReq}, 32'd1);
        chk("pr_memwe_d", {31'd0, MemWe}, 32'd1);
        chk("pr_memaddr_d", MemAddr, 32'h200);
        chk("pr_memwdata_d", MemWData, 32'hCAFEF00D);
        step();
        DReq = 1'b0;
        DWe  = 1'b0;
        push(1'b0, 32'h22222222);
        MemRData = 32'h22222222;
        @(negedge clk);
        chk("pr_memreq_i", {31'd0, MemReq}, 32'd1);
        chk("pr_memwe_i", {31'd0, MemWe}, 32'd0);
        chk("pr_memaddr_i", MemAddr, 32'h300);
        chk("pr_memwdata_i", MemWData, 32'hCAFEF00D);
        step();
        IReq   = 1'b0;
        MemAck = 1'b0;
        @(negedge clk);
        chk("pr_memreq_drop", {31'd0, MemReq}, 32'd0);

        // Continuous traffic, ack every cycle: grants alternate D,I,D,I,...
        do_reset();
        IReq  = 1'b1;
        IAddr = 32'h500;
        DReq  = 1'b1;
        DAddr = 32'h400;
        step();
        for (int k = 0; k < 6; k++) begin
            push((k % 2) == 0, 32'hA0 + k);
            MemAck   = 1'b1;
            MemRData = 32'hA0 + k;
            @(negedge clk);
            chk("rr_memreq", {31'd0, MemReq}, 32'd1);
            chk("rr_memaddr", MemAddr, ((k % 2) == 0) ? 32'h400 : 32'h500);
            step();
        end
        // D was re-granted on the last ack; dropping DReq does not cancel its completion.
        IReq = 1'b0;
        DReq = 1'b0;
        push(1'b1, 32'hA6);
        MemRData = 32'hA6;
        @(negedge clk);
        chk("rr_memaddr_last", MemAddr, 32'h400);
        step();
        MemAck = 1'b0;
        @(negedge clk);
        chk("rr_memreq_drop", {31'd0, MemReq}, 32'd0);

        // Watchdog: load never acknowledged, aborts on the TIMEOUT-th BUSY cycle
        do_reset();
        DReq     = 1'b1;
        DAddr    = 32'h600;
        MemRData = 32'hDEADBEEF;
        step();
        for (int b = 0; b < TIMEOUT; b++) begin
            if (b == TIMEOUT - 1)
                push(1'b1, 32'd0);
            @(negedge clk);
            chk("to_memreq_busy", {31'd0, MemReq}, 32'd1);
            chk("to_memerror_pre", {31'd0, MemError}, 32'd0);
            step();
        end
        DReq = 1'b0;
        @(negedge clk);
        chk("to_memerror_set", {31'd0, MemError}, 32'd1);
        chk("to_memreq_drop", {31'd0, MemReq}, 32'd0);
        IReq  = 1'b1;
        IAddr = 32'h700;
        step();
        push(1'b0, 32'h12345678);
        MemAck   = 1'b1;
        MemRData = 32'h12345678;
        @(negedge clk);
        chk("to_next_memaddr", MemAddr, 32'h700);
        step();
        IReq   = 1'b0;
        MemAck = 1'b0;
        @(negedge clk);
        chk("to_memerror_sticky", {31'd0, MemError}, 32'd1);

        // Reset during DBUSY with a same-cycle ack: no DReady, everything back to reset values
        do_reset();
        DReq   = 1'b1;
        DWe    = 1'b1;
        DAddr  = 32'h800;
        DWData = 32'h55;
        step();
        @(negedge clk);
        chk("mr_memreq_busy", {31'd0, MemReq}, 32'd1);
        reset    = 1'b1;
        MemAck   = 1'b1;
        MemRData = 32'h55;
        step();
        DReq = 1'b0;
        DWe  = 1'b0;
        @(negedge clk);
        chk("mr_memreq", {31'd0, MemReq}, 32'd0);
        chk("mr_memwe", {31'd0, MemWe}, 32'd0);
        chk("mr_memaddr", MemAddr, 32'd0);
        chk("mr_memwdata", MemWData, 32'd0);
        chk("mr_stallcnt", {16'd0, StallCnt}, 32'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("mr_memreq_after", {31'd0, MemReq}, 32'd0);
        step();
        MemAck = 1'b0;
        @(negedge clk);
        chk("mr_memreq_after2", {31'd0, MemReq}, 32'd0);

        // Slow memory: 10 stalled cycles, then a stray ack while idle
        do_reset();
        IReq  = 1'b1;
        IAddr = 32'h900;
        step();
        for (int b = 0; b < 10; b++) begin
            if (b == 9) begin
                push(1'b0, 32'h99);
                MemAck   = 1'b1;
                MemRData = 32'h99;
            end
            step();
        end
        IReq = 1'b0;
        @(negedge clk);
        chk("st_stallcnt", {16'd0, StallCnt}, 32'd10);
        chk("st_memreq_idle", {31'd0, MemReq}, 32'd0);
        step();
        MemAck = 1'b0;
        @(negedge clk);
        chk("st_stallcnt_hold", {16'd0, StallCnt}, 32'd10);

        repeat (3) step();
        chk("pending_expectations", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
